// File: rtl/td_alu_pkg.sv
// Shared types for the sequential time-domain ALU: opcodes, FSM states and
// the default counter width.
package td_alu_pkg;

    localparam int DEF_CNT_W = 8;

    typedef enum logic [2:0] {
        OP_MIN    = 3'b000,
        OP_MAX    = 3'b001,
        OP_CMP    = 3'b010,
        OP_SUB    = 3'b011,
        OP_PASS_A = 3'b100,
        OP_PASS_B = 3'b101,
        OP_ADD    = 3'b110,
        OP_RSVD   = 3'b111
    } td_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_EMIT    = 2'd3
    } td_state_e;

endpackage

// File: rtl/td_edge_timer.sv
// First-arrival capture of one edge-coded operand: records the shared time
// counter on the first enabled sample where the edge input is high.
module td_edge_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] t_i,
    input  logic             edge_i,
    output logic             seen_o,
    output logic [CNT_W-1:0] t_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            seen_o <= 1'b0;
            t_o    <= '0;
        end else if (en_i && !seen_o && edge_i) begin
            seen_o <= 1'b1;
            t_o    <= t_i;
        end
    end

endmodule

// File: rtl/td_alu_seq.sv
// Clocked time-domain ALU: measures operand arrival times against a start
// event, applies one of eight operations and re-emits the result as a delayed edge.
module td_alu_seq
    import td_alu_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int MAX_T = 2**CNT_W - 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic             a_i,
    input  logic             b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] result_o,
    output logic             timeout_o,
    output logic             y_o
);

    localparam logic [1:0] IDLE    = ST_IDLE;
    localparam logic [1:0] MEASURE = ST_MEASURE;
    localparam logic [1:0] COMPUTE = ST_COMPUTE;
    localparam logic [1:0] EMIT    = ST_EMIT;

    localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_T);

    logic [1:0]       state;
    td_op_e           op_q;
    logic [CNT_W-1:0] t;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] r_q;
    logic [CNT_W-1:0] ta;
    logic [CNT_W-1:0] tb;
    logic             seen_a;
    logic             seen_b;
    logic             accept;
    logic             measuring;
    logic             at_limit;
    logic             edge_a;
    logic             edge_b;
    logic             missing;
    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] alu_r;

    assign accept    = (state == IDLE) && start_i;
    assign measuring = (state == MEASURE);
    assign at_limit  = (t == MAX_V);
    assign busy_o    = (state != IDLE);

    // At the timeout sample every still-missing operand is forced to capture
    // MAX_T, so the normal "both seen" exit covers the timeout path as well.
    assign edge_a  = a_i | at_limit;
    assign edge_b  = b_i | at_limit;
    assign missing = !(seen_a || a_i) || !(seen_b || b_i);

    td_edge_timer #(.CNT_W(CNT_W)) u_timer_a (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (accept),
        .en_i   (measuring),
        .t_i    (t),
        .edge_i (edge_a),
        .seen_o (seen_a),
        .t_o    (ta)
    );

    td_edge_timer #(.CNT_W(CNT_W)) u_timer_b (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (accept),
        .en_i   (measuring),
        .t_i    (t),
        .edge_i (edge_b),
        .seen_o (seen_b),
        .t_o    (tb)
    );

    always_comb begin
        sum   = {1'b0, ta} + {1'b0, tb};
        alu_r = '0;
        case (op_q)
            OP_MIN:    alu_r = (ta < tb) ? ta : tb;
            OP_MAX:    alu_r = (ta > tb) ? ta : tb;
            OP_CMP:    alu_r = {{(CNT_W-1){1'b0}}, (ta < tb)};
            OP_SUB:    alu_r = (ta > tb) ? (ta - tb) : (tb - ta);
            OP_PASS_A: alu_r = ta;
            OP_PASS_B: alu_r = tb;
            OP_ADD:    alu_r = (sum > {1'b0, MAX_V}) ? MAX_V : sum[CNT_W-1:0];
            default:   alu_r = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            op_q      <= OP_MIN;
            t         <= '0;
            cnt       <= '0;
            r_q       <= '0;
            done_o    <= 1'b0;
            result_o  <= '0;
            timeout_o <= 1'b0;
            y_o       <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        op_q      <= td_op_e'(op_i);
                        t         <= '0;
                        y_o       <= 1'b0;
                        timeout_o <= 1'b0;
                        result_o  <= '0;
                        state     <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (!at_limit) begin
                        t <= t + 1'b1;
                    end
                    if (at_limit && missing) begin
                        timeout_o <= 1'b1;
                    end
                    if (seen_a && seen_b) begin
                        state <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    r_q   <= alu_r;
                    cnt   <= alu_r;
                    state <= EMIT;
                end
                EMIT: begin
                    // The zero-count cycle is the re-timed output edge.
                    if (cnt == '0) begin
                        y_o      <= 1'b1;
                        done_o   <= 1'b1;
                        result_o <= r_q;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_td_alu_seq.sv
// Randomised and directed bench for td_alu_seq, checked every cycle against a
// transaction-level model of arrival times, operation result and latency.
module tb_td_alu_seq;

    localparam int W    = 8;
    localparam int MAXT = 255;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         start_i;
    logic [2:0]   op_i;
    logic         a_i;
    logic         b_i;
    logic         busy_o;
    logic         done_o;
    logic [W-1:0] result_o;
    logic         timeout_o;
    logic         y_o;

    int checks = 0;
    int errors = 0;

    int mode   = 2;
    int txn_id = 0;
    int exp_r  = 0;
    int exp_d  = 0;
    bit exp_tmo = 1'b0;
    bit lit_on  = 1'b0;
    int lit_r   = 0;
    int lit_d   = 0;
    bit lit_tmo = 1'b0;

    int mon_id = 0;
    int mon_n  = 0;
    int y_rise = -1;

    always #5 clk_i = ~clk_i;

    td_alu_seq #(.CNT_W(W), .MAX_T(MAXT)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .op_i      (op_i),
        .a_i       (a_i),
        .b_i       (b_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .result_o  (result_o),
        .timeout_o (timeout_o),
        .y_o       (y_o)
    );

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: arrival index k becomes the measured time,
    // clipped to MAXT on timeout; the edge appears T+4+R edges after the start edge.
    function automatic void modelOp(input int op, input int ka, input int kb,
                                    output int r, output bit tmo, output int d);
        int ta;
        int tb;
        ta  = (ka > MAXT) ? MAXT : ka;
        tb  = (kb > MAXT) ? MAXT : kb;
        tmo = (ka > MAXT) || (kb > MAXT);
        case (op)
            0: r = (ta < tb) ? ta : tb;
            1: r = (ta > tb) ? ta : tb;
            2: r = (ta < tb) ? 1 : 0;
            3: r = (ta > tb) ? ta - tb : tb - ta;
            4: r = ta;
            5: r = tb;
            6: r = (ta + tb > MAXT) ? MAXT : ta + tb;
            default: r = 0;
        endcase
        d = ((ta > tb) ? ta : tb) + 4 + r;
    endfunction

    // Single compare process: mon_n counts edges since the accepting start edge.
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            if (mode == 2) begin
                checkOutput("rst_busy", busy_o, 0);
                checkOutput("rst_done", done_o, 0);
                checkOutput("rst_y", y_o, 0);
                checkOutput("rst_result", result_o, 0);
                checkOutput("rst_timeout", timeout_o, 0);
            end else if (mode == 1) begin
                if (txn_id != mon_id) begin
                    mon_id = txn_id;
                    mon_n  = 0;
                    y_rise = -1;
                end else begin
                    mon_n++;
                end
                if (y_o && y_rise < 0) y_rise = mon_n;
                if (mon_n < exp_d) begin
                    checkOutput("busy", busy_o, 1);
                    checkOutput("done", done_o, 0);
                    checkOutput("y", y_o, 0);
                    checkOutput("result_pending", result_o, 0);
                end else begin
                    checkOutput("busy", busy_o, 0);
                    checkOutput("done", done_o, (mon_n == exp_d) ? 1 : 0);
                    checkOutput("y", y_o, 1);
                    checkOutput("result", result_o, exp_r);
                    checkOutput("timeout", timeout_o, exp_tmo);
                    if (mon_n == exp_d && lit_on) begin
                        checkOutput("lit_result", result_o, lit_r);
                        checkOutput("lit_timeout", timeout_o, lit_tmo);
                        checkOutput("lit_y_edge", y_rise, lit_d);
                    end
                end
            end
        end
    end

    task automatic startTxn(input int op, input int ka, input int kb, input bit lit,
                            input int lr, input int ld, input bit lt);
        @(negedge clk_i);
        start_i = 1'b1;
        op_i    = 3'(op);
        a_i     = 1'b0;
        b_i     = 1'b0;
        modelOp(op, ka, kb, exp_r, exp_tmo, exp_d);
        lit_on  = lit;
        lit_r   = lr;
        lit_d   = ld;
        lit_tmo = lt;
        mode    = 1;
        txn_id++;
    endtask

    task automatic driveOps(input int ka, input int kb, input bit pulse, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk_i);
            start_i = pulse && (c == 2);
            if (pulse && c == 2) op_i = 3'($urandom_range(0, 7));
            a_i = (c >= ka);
            b_i = (c >= kb);
        end
    endtask

    task automatic applyStimulus(input int op, input int ka, input int kb, input bit pulse,
                                 input int idle, input bit lit, input int lr,
                                 input int ld, input bit lt);
        startTxn(op, ka, kb, lit, lr, ld, lt);
        driveOps(ka, kb, pulse, exp_d);
        repeat (idle) begin
            @(negedge clk_i);
            start_i = 1'b0;
        end
    endtask

    initial begin
        int op;
        int ka;
        int kb;
        rst_i   = 1'b1;
        start_i = 1'b0;
        op_i    = 3'd0;
        a_i     = 1'b0;
        b_i     = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);

        applyStimulus(0, 5, 9, 0, 2, 1, 5, 18, 0);
        applyStimulus(3, 12, 4, 0, 0, 1, 8, 24, 0);
        applyStimulus(5, 12, 4, 0, 2, 1, 4, 20, 0);
        applyStimulus(6, 200, 100, 0, 1, 1, 255, 459, 0);
        applyStimulus(1, 3, 1000, 0, 1, 1, 255, 514, 1);
        applyStimulus(2, 7, 7, 0, 1, 1, 0, 11, 0);
        applyStimulus(2, 2, 6, 0, 1, 1, 1, 11, 0);
        applyStimulus(7, 4, 9, 0, 1, 1, 0, 13, 0);
        applyStimulus(0, 10, 20, 1, 1, 1, 10, 34, 0);
        applyStimulus(0, 0, 0, 0, 1, 1, 0, 4, 0);

        // Reset deep in EMIT, together with a start request that must lose.
        startTxn(4, 50, 2, 0, 0, 0, 0);
        driveOps(50, 2, 0, 60);
        @(negedge clk_i);
        rst_i   = 1'b1;
        start_i = 1'b1;
        mode    = 2;
        @(negedge clk_i);
        rst_i   = 1'b0;
        start_i = 1'b0;
        repeat (120) @(negedge clk_i);

        for (int i = 0; i < 25; i++) begin
            op = $urandom_range(0, 7);
            ka = ($urandom_range(0, 7) == 0) ? 300 : $urandom_range(0, 40);
            kb = ($urandom_range(0, 7) == 0) ? 300 : $urandom_range(0, 40);
            applyStimulus(op, ka, kb, 1'($urandom_range(0, 1)),
                          $urandom_range(0, 2), 0, 0, 0, 0);
        end

        repeat (3) @(negedge clk_i);
        mode = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/td_alu_seq.md
# td_alu_seq

Clocked, parametrised time-domain ALU. It measures the arrival times of two edge-coded operands against a start event and computes one of eight time-domain operations on the measured values. It returns the result both as a binary word and as a regenerated output edge delayed by the result in clock cycles. It sits between upstream edge-coded producers and downstream time-domain consumers, and adds what the combinational TD ALU lacks: measurement windows, timeout, ADD, and result re-timing.

## Interface
Parameters:
- `CNT_W`, default 8: width of the time counter and of the result.
- `MAX_T`, default 2**CNT_W-1: timeout value and saturation limit.

Ports:
- `clk_i` input, 1 bit: the single clock.
- `rst_i` input, 1 bit: reset, synchronous and active-high.
- `start_i` input, 1 bit: starts a measurement window.
- `op_i` input, 3 bits: operation select, latched when `start_i` is accepted.
- `a_i` input, 1 bit: operand A edge, level-high after arrival, already synchronous to `clk_i`.
- `b_i` input, 1 bit: operand B edge, same rules as `a_i`.
- `busy_o` output, 1 bit: high in every state except IDLE.
- `done_o` output, 1 bit: one-cycle pulse when the result is ready.
- `result_o` output, CNT_W bits: binary result, valid from the `done_o` pulse until the next accepted start.
- `timeout_o` output, 1 bit: the last operation timed out; valid alongside `result_o`.
- `y_o` output, 1 bit: regenerated result edge.

## Operation
- FSM states: IDLE, MEASURE, COMPUTE, EMIT.
- **IDLE**
  - `start_i`=1 latches `op_i`, clears `t`, `ta`, `tb`, the arrival flags, `y_o`, `done_o`, `timeout_o` and `result_o`, then moves to MEASURE.
  - `start_i` is ignored in every other state.
- **MEASURE**
  - `t` increments by 1 every cycle. The first MEASURE sample is `t`=0.
  - The first sample with `a_i`=1 captures `ta`=`t`. The same rule applies to `b_i` and `tb`. Later samples do not change a captured value.
  - An input already high at the first sample captures 0.
  - The FSM leaves for COMPUTE once both operands are captured. Both captured on the same sample is legal.
  - If `t` reaches MAX_T with an operand missing, each missing operand takes MAX_T, `timeout_o` is set, and the FSM moves to COMPUTE.
- **COMPUTE** (one cycle) sets R by opcode:
  - 000 MIN: min(ta,tb).
  - 001 MAX: max(ta,tb).
  - 010 CMP: 1 if ta<tb, else 0.
  - 011 SUB: |ta−tb|.
  - 100 PASS_A: ta.
  - 101 PASS_B: tb.
  - 110 ADD: ta+tb, saturated to MAX_T; compute with a CNT_W+1-bit intermediate.
  - 111: reserved, R=0.
  - The FSM then loads the down-counter with R and moves to EMIT.
- **EMIT**
  - The counter decrements by 1 each cycle while nonzero.
  - In the cycle the counter is 0: register `y_o`=1, `done_o`=1 and `result_o`=R, then return to IDLE.
  - `y_o` stays high until the next accepted start.
- **Reset**
  - `rst_i` wins over every other input, including a simultaneous `start_i`.
  - Reset mid-operation returns the block to IDLE with all outputs at 0.

## Timing
- Reset value of every output (`busy_o`, `done_o`, `result_o`, `timeout_o`, `y_o`) is 0.
- Let L be the clock edge that samples the final operand, or the timeout edge.
  - Edge L+1: state becomes COMPUTE.
  - Edge L+2: state becomes EMIT, counter holds R.
  - Edge L+3+R: `y_o` and `done_o` go high.
- `busy_o` deasserts in the same cycle that `done_o` pulses.
- Total latency from accepting start: T+4+R cycles, where T is the sample index of the final operand.
- Back-to-back: `start_i` held high during the `done_o` cycle is accepted on the following edge.

## Structure
- Package `td_alu_pkg` holds:
  - the `td_op_e` opcode enum (values as listed above);
  - the `td_state_e` FSM enum;
  - the `DEF_CNT_W` constant.
- Sub-module `td_edge_timer` (parameter CNT_W, instantiated once per operand):
  - Inputs: `clk_i`, `rst_i`, `clr_i`, `en_i`, `t_i`, `edge_i`.
  - Outputs: `seen_o`, `t_o`.
  - Function: first-arrival capture.
- Top level holds the FSM, the shared `t` counter, the ALU function and the EMIT down-counter.

## Test plan
All scenarios use CNT_W=8.
- MIN, `a_i` rises at t=5, `b_i` at t=9 → `result_o`=5; `y_o` rises 8 edges after the t=9 sample edge; `done_o` high for exactly 1 cycle.
- SUB, `a_i` at 12, `b_i` at 4 → `result_o`=8. PASS_B with the same stimulus → `result_o`=4.
- ADD, `a_i` at 200, `b_i` at 100 → `result_o`=255, `timeout_o`=0.
- MAX, `a_i` at 3, `b_i` never rises → `timeout_o`=1, `result_o`=255, `y_o` rises 258 edges after the t=255 edge.
- CMP tie, both inputs at 7 → `result_o`=0, `y_o` rises at L+3. CMP with `a_i`=2, `b_i`=6 → `result_o`=1.
- `start_i` pulsed mid-MEASURE → ignored, result unchanged. `rst_i` mid-EMIT → next cycle IDLE, `busy_o`=`y_o`=`done_o`=0, no `done_o` pulse follows.
